// File: rtl/reflet_ram8_arbiter_pkg.sv
// Shared types and constants for the reflet_ram8 two-port arbiter.
package reflet_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } arb_state_t;

    localparam int unsigned NUM_PORTS    = 2;
    localparam int unsigned MAX_WORDSIZE = 4;
    localparam int unsigned BYTE_IDX_W   = $clog2(MAX_WORDSIZE);

endpackage

// File: rtl/reflet_rr_arbiter2.sv
// Two-port request arbiter; round-robin by default, fixed priority (port 0 wins)
// when REFLET_RAM_ARB_FIXED_PRIORITY_EN is defined.
module reflet_rr_arbiter2
    import reflet_ram_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 grant_en,
    output logic [NUM_PORTS-1:0] grant
);

`ifdef REFLET_RAM_ARB_FIXED_PRIORITY_EN
    always_comb begin
        grant = '0;
        if (req[0])
            grant = 2'b01;
        else if (req[1])
            grant = 2'b10;
    end
`else
    logic ptr;

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = ptr ? 2'b10 : 2'b01;
    end

    // After any grant, the pointer favours the port that was not served.
    always_ff @(posedge clk) begin
        if (!reset)
            ptr <= 1'b0;
        else if (grant_en && |grant)
            ptr <= grant[0];
    end
`endif

endmodule

// File: rtl/reflet_ram8_arbiter.sv
// Shares one reflet_ram8 byte RAM between two word-wide requesters, sequencing
// each little-endian word access into per-byte RAM cycles.
module reflet_ram8_arbiter
    import reflet_ram_arb_pkg::*;
#(
    parameter int addrSize = 7,
    parameter int wordsize = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    we0,
    input  logic [addrSize-1:0]     addr0,
    input  logic [8*wordsize-1:0]   wdata0,
    output logic [8*wordsize-1:0]   rdata0,
    output logic                    ack0,
    input  logic                    req1,
    input  logic                    we1,
    input  logic [addrSize-1:0]     addr1,
    input  logic [8*wordsize-1:0]   wdata1,
    output logic [8*wordsize-1:0]   rdata1,
    output logic                    ack1,
    output logic                    ram_enable,
    output logic [addrSize-1:0]     ram_addr,
    output logic [7:0]              ram_data_in,
    output logic                    ram_write_en,
    input  logic [7:0]              ram_data_out
);

    arb_state_t                state, state_nx;
    logic [BYTE_IDX_W-1:0]     k;
    logic                      gnt_port;
    logic                      we_q;
    logic [addrSize-1:0]       addr_q;
    logic [8*wordsize-1:0]     wdata_q;
    logic [NUM_PORTS-1:0]      req_v;
    logic [NUM_PORTS-1:0]      grant;
    logic                      grant_en;
    logic                      last_byte;
    logic [addrSize-1:0]       byte_addr;

    assign req_v     = {req1, req0};
    assign grant_en  = (state == IDLE) && (|req_v);
    assign last_byte = (k == BYTE_IDX_W'(wordsize - 1));
    assign byte_addr = addr_q + addrSize'(k);

    reflet_rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req_v),
        .grant_en (grant_en),
        .grant    (grant)
    );

    always_comb begin
        state_nx     = state;
        ram_enable   = 1'b0;
        ram_addr     = '0;
        ram_data_in  = '0;
        ram_write_en = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        case (state)
            IDLE: begin
                if (|req_v)
                    state_nx = ISSUE;
            end
            ISSUE: begin
                ram_enable   = 1'b1;
                ram_addr     = byte_addr;
                ram_data_in  = wdata_q[8*k +: 8];
                ram_write_en = we_q;
                if (!we_q)
                    state_nx = CAPTURE;
                else if (last_byte)
                    state_nx = DONE;
            end
            CAPTURE: begin
                // RAM output is combinational on enable/addr, so keep them stable.
                ram_enable = 1'b1;
                ram_addr   = byte_addr;
                state_nx   = last_byte ? DONE : ISSUE;
            end
            DONE: begin
                ack0     = ~gnt_port;
                ack1     = gnt_port;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            k        <= '0;
            gnt_port <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (|req_v) begin
                        gnt_port <= grant[1];
                        we_q     <= grant[1] ? we1    : we0;
                        addr_q   <= grant[1] ? addr1  : addr0;
                        wdata_q  <= grant[1] ? wdata1 : wdata0;
                        k        <= '0;
                    end
                end
                ISSUE: begin
                    if (we_q && !last_byte)
                        k <= k + 1'b1;
                end
                CAPTURE: begin
                    if (gnt_port)
                        rdata1[8*k +: 8] <= ram_data_out;
                    else
                        rdata0[8*k +: 8] <= ram_data_out;
                    if (!last_byte)
                        k <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_ram8_arbiter.sv
// Self-checking bench for reflet_ram8_arbiter: directed cases plus random rounds
// checked against a word-level model of memory, grant order and latency.
module tb_reflet_ram8_arbiter;

    localparam int AW = 7;
    localparam int WS = 2;
    localparam int DW = 8 * WS;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;
    logic          ack0, ack1;
    logic          ram_enable, ram_write_en;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data_in, ram_data_out;

    always #5 clk = ~clk;

    reflet_ram8_arbiter #(.addrSize(AW), .wordsize(WS)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .we0          (we0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .rdata0       (rdata0),
        .ack0         (ack0),
        .req1         (req1),
        .we1          (we1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .rdata1       (rdata1),
        .ack1         (ack1),
        .ram_enable   (ram_enable),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_write_en (ram_write_en),
        .ram_data_out (ram_data_out)
    );

    // Behavioural reflet_ram8 with a configurable populated size.
    logic [7:0] mem [0:127];
    logic       clear_mem;
    int         ram_size;

    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
        end else if (ram_enable && ram_write_en && int'(ram_addr) < ram_size) begin
            mem[ram_addr] <= ram_data_in;
        end
    end
    assign ram_data_out = (ram_enable && int'(ram_addr) < ram_size) ? mem[ram_addr] : 8'h00;

    // Reference model state.
    logic [7:0]    model_mem [0:127];
    logic [DW-1:0] m_rdata [2];
    logic          m_ptr;
    logic          t_we [2];
    logic [AW-1:0] t_addr [2];
    logic [DW-1:0] t_wdata [2];

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_txn(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        t_we[p]    = we;
        t_addr[p]  = a;
        t_wdata[p] = d;
    endtask

    task automatic apply_model(input int p);
        for (int i = 0; i < WS; i++) begin
            int a;
            a = (int'(t_addr[p]) + i) % 128;
            if (t_we[p]) begin
                if (a < ram_size) model_mem[a] = t_wdata[p][8*i +: 8];
            end else begin
                m_rdata[p][8*i +: 8] = (a < ram_size) ? model_mem[a] : 8'h00;
            end
        end
    endtask

    // Raise the requests in mask together (DUT in IDLE) and serve them to completion.
    // cnt counts cycles with the IDLE cycle that samples req as cycle 1.
    task automatic run_round(input logic [1:0] mask);
        logic [1:0] pend;
        int cnt, p, exp_p;
        pend   = mask;
        req0   = mask[0]; we0 = t_we[0]; addr0 = t_addr[0]; wdata0 = t_wdata[0];
        req1   = mask[1]; we1 = t_we[1]; addr1 = t_addr[1]; wdata1 = t_wdata[1];
        cnt    = 1;
        while (pend != 2'b00) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt > 40) begin
                check("ack_timeout", {30'd0, pend}, 32'd0);
                pend = 2'b00;
                req0 = 1'b0;
                req1 = 1'b0;
            end else if (ack0 || ack1) begin
                p = ack1 ? 1 : 0;
`ifdef REFLET_RAM_ARB_FIXED_PRIORITY_EN
                exp_p = pend[0] ? 0 : 1;
`else
                if (pend == 2'b11) exp_p = m_ptr ? 1 : 0;
                else               exp_p = pend[1] ? 1 : 0;
                m_ptr = (p == 0);
`endif
                check("grant_port", p, exp_p);
                check("ack_onehot", {30'd0, ack1, ack0}, 32'd1 << exp_p);
                check("latency", cnt, t_we[p] ? WS + 2 : 2 * WS + 2);
                check("ram_en_in_done", ram_enable, 1'b0);
                apply_model(p);
                check("rdata0", rdata0, m_rdata[0]);
                check("rdata1", rdata1, m_rdata[1]);
                pend[p] = 1'b0;
                if (p == 0) req0 = 1'b0; else req1 = 1'b0;
                cnt = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int bad;
        logic [1:0] mask;
        reset = 1'b0; clear_mem = 1'b1; ram_size = 128;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
        m_rdata[0] = '0; m_rdata[1] = '0; m_ptr = 1'b0;
        for (int i = 0; i < 2; i++) set_txn(i, 1'b0, '0, '0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", ack0, 1'b0);
        check("rst_ack1", ack1, 1'b0);
        check("rst_rdata0", rdata0, '0);
        check("rst_rdata1", rdata1, '0);
        check("rst_ram_en", ram_enable, 1'b0);
        check("rst_ram_we", ram_write_en, 1'b0);
        check("rst_ram_addr", ram_addr, '0);
        check("rst_ram_din", ram_data_in, '0);
        clear_mem = 1'b0;
        reset     = 1'b1;

        // Port 0 word write then read back.
        set_txn(0, 1'b1, 7'h10, 16'hBEEF);
        run_round(2'b01);
        check("mem_10", mem[7'h10], 8'hEF);
        check("mem_11", mem[7'h11], 8'hBE);
        set_txn(0, 1'b0, 7'h10, '0);
        run_round(2'b01);
        check("read_beef", rdata0, 16'hBEEF);
        check("rdata1_untouched", rdata1, 16'h0000);

        // Simultaneous requests over three rounds.
        set_txn(0, 1'b1, 7'h20, 16'h1111);
        set_txn(1, 1'b1, 7'h30, 16'h2222);
        repeat (3) run_round(2'b11);

        // Address wrap at the top of a 128-byte RAM.
        set_txn(1, 1'b1, 7'h7F, 16'h1234);
        run_round(2'b10);
        check("mem_7f", mem[7'h7F], 8'h34);
        check("mem_00_wrap", mem[7'h00], 8'h12);

        // 100-byte RAM: upper byte of the word at 0x63 lies out of range.
        ram_size = 100;
        set_txn(0, 1'b1, 7'h63, 16'h55AA);
        run_round(2'b01);
        set_txn(0, 1'b0, 7'h63, '0);
        run_round(2'b01);
        check("oor_read", rdata0, 16'h00AA);
        ram_size = 128;

        // Reset during CAPTURE of a read: transaction abandoned without ack.
        set_txn(0, 1'b0, 7'h10, '0);
        run_round(2'b01);
        req0 = 1'b1; we0 = 1'b0; addr0 = 7'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("capture_enable", ram_enable, 1'b1);
        check("capture_no_we", ram_write_en, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_ack0", ack0, 1'b0);
        check("abort_rdata0", rdata0, '0);
        check("abort_rdata1", rdata1, '0);
        check("abort_ram_en", ram_enable, 1'b0);
        req0  = 1'b0;
        reset = 1'b1;
        m_rdata[0] = '0; m_rdata[1] = '0; m_ptr = 1'b0;
        run_round(2'b01);
        check("post_reset_read", rdata0, 16'hBEEF);

        // Random rounds against the model.
        for (int r = 0; r < 25; r++) begin
            mask     = 2'($urandom_range(1, 3));
            ram_size = ($urandom_range(0, 1) == 0) ? 100 : 128;
            for (int p = 0; p < 2; p++)
                set_txn(p, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 16'($urandom));
            run_round(mask);
        end

        bad = 0;
        for (int i = 0; i < 128; i++)
            if (mem[i] !== model_mem[i]) bad++;
        check("mem_final", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reflet_ram8_arbiter.md
Name: reflet_ram8_arbiter

Overview:
Shares one reflet_ram8 byte RAM between two requesters (port 0: CPU, port 1: DMA/peripheral) with round-robin arbitration. Each request is a multi-byte little-endian word access; the block sequences it into per-byte RAM cycles, then returns a one-cycle acknowledge. It sits directly between the bus decoders and the RAM instance.

Parameters:
addrSize, 7, RAM byte-address width; must match the RAM instance.
wordsize, 2, bytes per transaction, legal 1..4.

Ports:
clk  in  1  clock
reset  in  1  reset reset, synchronous, active-low
req0  in  1  port 0 request; held high until ack0
we0  in  1  port 0 write (1) / read (0)
addr0  in  addrSize  port 0 byte address of least-significant byte
wdata0  in  8*wordsize  port 0 write data
rdata0  out  8*wordsize  port 0 read data
ack0  out  1  port 0 completion pulse
req1, we1, addr1, wdata1, rdata1, ack1: same as port 0, for port 1
ram_enable  out  1  to RAM enable
ram_addr  out  addrSize  to RAM addr
ram_data_in  out  8  to RAM data_in
ram_write_en  out  1  to RAM write_en
ram_data_out  in  8  from RAM data_out

Behaviour:
- Reset (reset low at posedge): state IDLE, ack0/ack1 = 0, rdata0/rdata1 = 0, all ram_* outputs = 0, round-robin pointer = port 0. Takes effect mid-transaction; in-flight access is abandoned with no ack.
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the port the pointer selects; pointer then moves to the other port. Pointer updates only on a grant. At grant, latch we, addr, wdata; byte index k = 0; go ISSUE.
- Byte address = (addr + k) mod 2^addrSize (wraps, no carry out).
- ISSUE: ram_enable = 1, ram_addr = byte address, ram_data_in = wdata byte k.
  - Write: ram_write_en = 1 for this single cycle. If k = wordsize-1, go DONE; else k+1, stay ISSUE.
  - Read: ram_write_en = 0; go CAPTURE.
- CAPTURE (reads only): ram_enable and ram_addr held at the ISSUE values, because the RAM gates data_out combinationally on enable/addr. At the closing clock edge, store ram_data_out into rdata byte k of the granted port. If k = wordsize-1, go DONE; else k+1, go ISSUE.
- DONE: ram_* = 0; ack of the granted port = 1 for exactly this cycle; next state IDLE.
  - Requester must drop req in the ack cycle. A req still high in the following IDLE cycle is treated as a new request.
- Latency from req sampled in IDLE to ack: write = wordsize + 2 cycles; read = 2*wordsize + 2 cycles.
- rdata of a port changes only during that port's reads; it holds its value after ack. rdata of the non-granted port is never disturbed.
- Out-of-range byte address (>= RAM size): writes are dropped by the RAM; reads return 0x00 for that byte. No error is flagged.
- Requester inputs are don't-care after grant. Dropping req before ack is illegal; the transaction still completes and acks.
- ram_enable is never high in IDLE or DONE. Byte writes are never issued out of ascending k order.

Optional Feature:
REFLET_RAM_ARB_FIXED_PRIORITY_EN
- Defined: port 0 always wins simultaneous requests; round-robin pointer removed.
- Undefined: round-robin as above.

Decomposition:
- Package reflet_ram_arb_pkg:
  - state enum (IDLE, ISSUE, CAPTURE, DONE);
  - NUM_PORTS = 2;
  - byte-index width constant, derived from the wordsize limit of 4.
- One natural sub-module: reflet_rr_arbiter2. Inputs req[1:0] and a grant strobe; outputs a one-hot grant and owns the pointer flop. Fixed-priority variant selected there under the macro.

Test Plan:
- wordsize=2, port0 write addr=0x10 wdata=0xBEEF -> RAM[0x10]=0xEF, RAM[0x11]=0xBE; ack0 pulses 4 cycles after req sampled.
- Port0 read addr=0x10 after the above -> rdata0=0xBEEF with ack0 at cycle 6; rdata1 unchanged.
- req0 and req1 asserted together, three back-to-back rounds -> grant order 0,1,0. With REFLET_RAM_ARB_FIXED_PRIORITY_EN: 0,0,0 while req0 stays asserted.
- Port1 write addr=0x7F wdata=0x1234 (addrSize=7, size=128) -> RAM[0x7F]=0x34, RAM[0x00]=0x12 (wrap).
- size=100, read addr=0x63 of a word with RAM[0x63]=0xAA -> rdata=0x00AA (out-of-range byte reads 0).
- Reset low during CAPTURE of a read -> next cycle IDLE, no ack, rdata=0, ram_enable=0; a fresh req after reset completes normally.
